// File: rtl/time_display_scanner.sv
// Multiplexed 4-digit common-anode 7-segment scanner for a 12-hour H1 H0 : M1 M0 clock.
// Frame-wide input snapshots, leading-zero blanking, dash on out-of-range and a blinking colon.
module time_display_scanner #(
  parameter int sys_freq = 100000000,
  parameter int digit_hz = 4000,
  parameter bit blink_en = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] hour,
  input  logic [3:0] tenmin,
  input  logic [3:0] min,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int DIV      = sys_freq / digit_hz;
  localparam int DIV_W    = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int BLINK_TC = sys_freq / 2;
  localparam int BLINK_W  = (BLINK_TC > 2) ? $clog2(BLINK_TC) : 1;

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  logic [DIV_W-1:0]   div_q;
  logic [BLINK_W-1:0] blink_q;
  logic               colon_q;
  logic [1:0]         idx_q;
  logic [1:0]         idx_d;
  logic               run_q;
  logic               upd_q;
  logic [3:0]         hour_q;
  logic [3:0]         tenmin_q;
  logic [3:0]         min_q;
  logic [3:0]         an_q;
  logic [6:0]         seg_q;
  logic               dp_q;
  logic [3:0]         an_d;
  logic [6:0]         seg_d;
  logic               dp_d;
  logic               tick;
  logic               hour_ok;
  logic [3:0]         dh;
  logic               h_tens;
  logic [3:0]         h_units;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_DASH;
    endcase
  endfunction

  assign tick = (div_q == DIV_W'(DIV - 1));

  // The first tick after reset starts a frame at M0 instead of advancing,
  // so the display always opens on a freshly captured snapshot.
  assign idx_d = run_q ? (idx_q + 2'd1) : 2'd0;

  assign hour_ok = (hour_q <= 4'd11);
  assign dh      = (hour_q == 4'd0) ? 4'd12 : hour_q;
  assign h_tens  = (dh >= 4'd10);
  assign h_units = h_tens ? (dh - 4'd10) : dh;

  always_comb begin
    seg_d = SEG_BLANK;
    case (idx_q)
      2'd0: seg_d = (min_q > 4'd9)    ? SEG_DASH : seg7(min_q);
      2'd1: seg_d = (tenmin_q > 4'd5) ? SEG_DASH : seg7(tenmin_q);
      2'd2: seg_d = hour_ok ? seg7(h_units) : SEG_DASH;
      2'd3: seg_d = !hour_ok ? SEG_DASH : (h_tens ? seg7(4'd1) : SEG_BLANK);
      default: seg_d = SEG_BLANK;
    endcase
    an_d = ~(4'b0001 << idx_q);
    dp_d = ~((idx_q == 2'd2) && colon_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= '0;
      idx_q    <= 2'd0;
      run_q    <= 1'b0;
      upd_q    <= 1'b0;
      hour_q   <= 4'd0;
      tenmin_q <= 4'd0;
      min_q    <= 4'd0;
      blink_q  <= '0;
      colon_q  <= 1'b1;
      an_q     <= 4'b1111;
      seg_q    <= SEG_BLANK;
      dp_q     <= 1'b1;
    end else begin
      div_q <= tick ? '0 : div_q + 1'b1;
      upd_q <= tick;

      if (tick) begin
        run_q <= 1'b1;
        idx_q <= idx_d;
        if (idx_d == 2'd0) begin
          hour_q   <= hour;
          tenmin_q <= tenmin;
          min_q    <= min;
        end
      end

      if (upd_q) begin
        an_q  <= an_d;
        seg_q <= seg_d;
        dp_q  <= dp_d;
      end

      if (blink_en) begin
        if (blink_q == BLINK_W'(BLINK_TC - 1)) begin
          blink_q <= '0;
          colon_q <= ~colon_q;
        end else begin
          blink_q <= blink_q + 1'b1;
        end
      end else begin
        blink_q <= '0;
        colon_q <= 1'b1;
      end
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_time_display_scanner.sv
// Cycle-level scoreboard bench: a time-based reference model pushes the expected
// display state every clock edge; the checker pops and compares on the falling edge.
module tb_time_display_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] hour = 4'd0;
  logic [3:0] tenmin = 4'd0;
  logic [3:0] min = 4'd0;
  logic [3:0] an, an2;
  logic [6:0] seg, seg2;
  logic       dp, dp2;

  int vectors = 0;
  int miscompares = 0;

  time_display_scanner #(.sys_freq(800), .digit_hz(100), .blink_en(1'b1)) dut (
    .clk(clk), .rst(rst), .hour(hour), .tenmin(tenmin), .min(min),
    .an(an), .seg(seg), .dp(dp)
  );

  time_display_scanner #(.sys_freq(800), .digit_hz(100), .blink_en(1'b0)) dut_steady (
    .clk(clk), .rst(rst), .hour(hour), .tenmin(tenmin), .min(min),
    .an(an2), .seg(seg2), .dp(dp2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       dp2;
    int         k;
  } exp_t;

  exp_t q[$];

  function automatic logic [6:0] seg_ref(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      10: return 7'b0111111;
      default: return 7'b1111111;
    endcase
  endfunction

  // Reference model: k counts edges since reset release. Frame starts every 32 edges
  // from edge 8; each digit slot shows from edge 8s+9 for 8 edges; colon halves are 400 edges.
  int k = 0;
  int sh_h = 0, sh_t = 0, sh_m = 0;

  always @(posedge clk) begin
    exp_t e;
    int s, idx, dig, dhv;
    bit c;
    e.an = 4'b1111; e.seg = 7'b1111111; e.dp = 1'b1; e.dp2 = 1'b1;
    if (rst) begin
      k = 0;
      sh_h = 0; sh_t = 0; sh_m = 0;
    end else begin
      k = k + 1;
      if (k >= 9) begin
        s   = (k - 9) / 8;
        idx = s % 4;
        dhv = (sh_h == 0) ? 12 : sh_h;
        case (idx)
          0: dig = (sh_m > 9) ? 10 : sh_m;
          1: dig = (sh_t > 5) ? 10 : sh_t;
          2: dig = (sh_h > 11) ? 10 : dhv % 10;
          default: dig = (sh_h > 11) ? 10 : ((dhv >= 10) ? dhv / 10 : 11);
        endcase
        e.an = 4'b1111;
        e.an[idx] = 1'b0;
        e.seg = seg_ref(dig);
        c = (((8 * s + 8) / 400) % 2) == 0;
        e.dp  = !(idx == 2 && c);
        e.dp2 = !(idx == 2);
      end
      if (k >= 8 && ((k - 8) % 32) == 0) begin
        sh_h = int'(hour); sh_t = int'(tenmin); sh_m = int'(min);
      end
    end
    e.k = k;
    q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      vectors++;
      assert (an === e.an) else begin
        miscompares++;
        $error("FAIL an k=%0d got %b want %b", e.k, an, e.an);
      end
      vectors++;
      assert (seg === e.seg) else begin
        miscompares++;
        $error("FAIL seg k=%0d an=%b got %b want %b", e.k, e.an, seg, e.seg);
      end
      vectors++;
      assert (dp === e.dp) else begin
        miscompares++;
        $error("FAIL dp k=%0d an=%b got %b want %b", e.k, e.an, dp, e.dp);
      end
      vectors++;
      assert (dp2 === e.dp2) else begin
        miscompares++;
        $error("FAIL dp_steady k=%0d an=%b got %b want %b", e.k, e.an, dp2, e.dp2);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // reset held for three edges, then 12:00 for the first frame
    cyc(3);
    rst = 1'b0;
    cyc(20);
    // 9:47 -> blank H1, captured at the next frame start
    hour = 4'd9; tenmin = 4'd4; min = 4'd7;
    cyc(30);
    // change while the M1 slot is shown: no effect until the next frame
    min = 4'd8;
    cyc(60);
    // mid-frame reset
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    // out-of-range on every field
    hour = 4'd13; tenmin = 4'd6; min = 4'd10;
    cyc(80);
    // two-digit hours across several colon periods
    hour = 4'd10; tenmin = 4'd3; min = 4'd5;
    cyc(800);
    hour = 4'd11; tenmin = 4'd5; min = 4'd9;
    cyc(900);
    hour = 4'd0; tenmin = 4'd0; min = 4'd1;
    cyc(100);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
